ksa_stage1_pipe: RTL and testbench

Registered pre-processing stage of the 32-bit Kogge-Stone adder. It takes two operands and an add/subtract select, and forms per-bit generate/propagate vectors with the carry-in folded into bit 0. The result sits in an output register behind a valid/ready handshake. `g_out`/`p_out` drive `KSA_stage2` directly, so the adder can be pipelined once the datapath leaves the single-cycle configuration.

---
 rtl/ksa_stage1_pipe_if.sv | 32 +++
 rtl/ksa_stage1_pipe.sv | 155 +++++++++++++++
 tb/tb_ksa_stage1_pipe.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ksa_stage1_pipe_if.sv
// ksa_stage1_pipe_if: operand/result handshake bundle of the Kogge-Stone
// pre-processing stage.
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both 1. A producer holds its payload stable while valid=1 and ready=0.
// Valid never waits on ready. Ready may depend on the consumer's own state.
interface ksa_stage1_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             sub_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] g_out;
   logic [WIDTH-1:0] p_out;
   logic             cin_out;

   // Upstream producer / downstream consumer side (testbench, neighbours)
   modport master (
      output in_valid, a_in, b_in, sub_in, out_ready,
      input  in_ready, out_valid, g_out, p_out, cin_out
   );

   // The stage itself
   modport slave (
      input  in_valid, a_in, b_in, sub_in, out_ready,
      output in_ready, out_valid, g_out, p_out, cin_out
   );
endinterface

// File: rtl/ksa_stage1_pipe.sv
// ksa_stage1_pipe: registered generate/propagate stage of a Kogge-Stone adder.
// b is inverted and the carry-in set for subtraction. The carry-in is folded
// into g[0]; p stays the raw half sum. The result waits in an output register
// behind a valid/ready handshake.
//
// Optional feature macro: KSA_STAGE1_SKID_EN
//   defined   : main register M plus a skid register S, registered in_ready
//   undefined : main register M only, in_ready = ~out_valid | out_ready
//
// WIDTH must be >= 2.
module ksa_stage1_pipe #(
   parameter int WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   ksa_stage1_pipe_if.slave    bus,
   output logic [1:0]          o_dbg_state
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,   // M empty
      ST_ONE   = 2'd1,   // M full, S empty
      ST_FULL  = 2'd2    // M and S full (skid build only)
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH-1:0] w_g_raw;
   logic [WIDTH-1:0] w_p;
   logic [WIDTH-1:0] w_g;
   logic             w_in_xfer;
   logic             w_load_m_in;

   logic [WIDTH-1:0] r_m_g;
   logic [WIDTH-1:0] r_m_p;
   logic             r_m_cin;

`ifdef KSA_STAGE1_SKID_EN
   logic             w_load_s;
   logic             w_load_m_s;
   logic [WIDTH-1:0] r_s_g;
   logic [WIDTH-1:0] r_s_p;
   logic             r_s_cin;
   logic             r_in_ready;
`endif

   // Generate/propagate from the effective operand, carry-in folded into bit 0
   always_comb begin
      w_b_eff = bus.sub_in ? ~bus.b_in : bus.b_in;
      w_g_raw = bus.a_in & w_b_eff;
      w_p     = bus.a_in ^ w_b_eff;
      w_g     = {w_g_raw[WIDTH-1:1], w_g_raw[0] | (w_p[0] & bus.sub_in)};
   end

   assign w_in_xfer = bus.in_valid & bus.in_ready;

   // Next-state and register load selects
   always_comb begin
      w_state_nxt = r_state;
      w_load_m_in = 1'b0;
`ifdef KSA_STAGE1_SKID_EN
      w_load_s    = 1'b0;
      w_load_m_s  = 1'b0;
`endif
      case (r_state)
         ST_EMPTY: begin
            if (w_in_xfer) begin
               w_load_m_in = 1'b1;
               w_state_nxt = ST_ONE;
            end
         end
         ST_ONE: begin
            if (w_in_xfer && bus.out_ready) begin
               w_load_m_in = 1'b1;
`ifdef KSA_STAGE1_SKID_EN
            end else if (w_in_xfer) begin
               // downstream stalled: park the new result behind M
               w_load_s    = 1'b1;
               w_state_nxt = ST_FULL;
`endif
            end else if (bus.out_ready) begin
               w_state_nxt = ST_EMPTY;
            end
         end
`ifdef KSA_STAGE1_SKID_EN
         ST_FULL: begin
            if (bus.out_ready) begin
               w_load_m_s  = 1'b1;
               w_state_nxt = ST_ONE;
            end
         end
`endif
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // State register; reset discards any held results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_EMPTY;
      else        r_state <= w_state_nxt;
   end

   // Main register M, the only source of the outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_g   <= '0;
         r_m_p   <= '0;
         r_m_cin <= 1'b0;
      end else if (w_load_m_in) begin
         r_m_g   <= w_g;
         r_m_p   <= w_p;
         r_m_cin <= bus.sub_in;
`ifdef KSA_STAGE1_SKID_EN
      end else if (w_load_m_s) begin
         r_m_g   <= r_s_g;
         r_m_p   <= r_s_p;
         r_m_cin <= r_s_cin;
`endif
      end
   end

`ifdef KSA_STAGE1_SKID_EN
   // Skid register S catches the one result accepted while M is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s_g   <= '0;
         r_s_p   <= '0;
         r_s_cin <= 1'b0;
      end else if (w_load_s) begin
         r_s_g   <= w_g;
         r_s_p   <= w_p;
         r_s_cin <= bus.sub_in;
      end
   end

   // Registered ready: low exactly while both entries are occupied
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_in_ready <= 1'b1;
      else        r_in_ready <= (w_state_nxt != ST_FULL);
   end

   assign bus.in_ready = r_in_ready;
`else
   assign bus.in_ready = (r_state == ST_EMPTY) | bus.out_ready;
`endif

   assign bus.out_valid = (r_state != ST_EMPTY);
   assign bus.g_out     = r_m_g;
   assign bus.p_out     = r_m_p;
   assign bus.cin_out   = r_m_cin;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_ksa_stage1_pipe.sv
// tb_ksa_stage1_pipe: bench for ksa_stage1_pipe. A queue holds the expected
// g/p/cin/sum of every accepted pair. Each cycle a compare process checks
// occupancy, ready and the head result against it. The sum is rebuilt from
// the DUT's g/p/cin by a ripple carry and checked against plain a+b / a-b.
module tb_ksa_stage1_pipe;
   localparam int W     = 32;
   localparam int EW    = 3*W + 1;
   localparam int BOUND = 200;

   logic       clk;
   logic       rst_n;
   logic [1:0] dbg_state;
   int         n_checks;
   int         n_errors;
   int         cyc;

   logic [EW-1:0] exp_q[$];

   ksa_stage1_pipe_if #(.WIDTH(W)) bus ();

   ksa_stage1_pipe #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- model ----------------
   // Packed expectation: {cin, sum, g, p}
   function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
      logic [W-1:0] be;
      logic [W-1:0] g;
      logic [W-1:0] p;
      logic [W-1:0] s;
      be   = sub ? ~b : b;
      g    = a & be;
      p    = a ^ be;
      g[0] = g[0] | (p[0] & sub);
      s    = sub ? (a - b) : (a + b);
      return {sub, s, g, p};
   endfunction

   // Finish the addition from a g/p/cin triple
   function automatic logic [W-1:0] ripple(input logic [W-1:0] g, input logic [W-1:0] p,
                                           input logic cin);
      logic         c;
      logic [W-1:0] s;
      s[0] = p[0] ^ cin;
      c    = g[0];
      for (int i = 1; i < W; i++) begin
         s[i] = p[i] ^ c;
         c    = g[i] | (p[i] & c);
      end
      return s;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic pin(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sub, input logic [W-1:0] eg, input logic [W-1:0] ep,
                      input logic esum_cin, input logic [W-1:0] esum);
      logic [EW-1:0] e;
      e = model(a, b, sub);
      check({name, "_g"},   e[W-1+W:W],   eg);
      check({name, "_p"},   e[W-1:0],     ep);
      check({name, "_cin"}, {31'd0, e[EW-1]}, {31'd0, esum_cin});
      check({name, "_sum"}, e[3*W-1:2*W], esum);
   endtask

   // ---------------- scoreboard / compare ----------------
   always @(negedge clk) begin
      logic [EW-1:0] e;
      logic          exp_rdy;
      if (rst_n) begin
         check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
`ifdef KSA_STAGE1_SKID_EN
         exp_rdy = (exp_q.size() < 2);
`else
         exp_rdy = (exp_q.size() == 0) || bus.out_ready;
`endif
         check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
         if (bus.out_valid && exp_q.size() != 0) begin
            e = exp_q[0];
            check("g_out",   bus.g_out, e[2*W-1:W]);
            check("p_out",   bus.p_out, e[W-1:0]);
            check("cin_out", {31'd0, bus.cin_out}, {31'd0, e[EW-1]});
            check("sum",     ripple(bus.g_out, bus.p_out, bus.cin_out), e[3*W-1:2*W]);
            if (bus.out_ready) void'(exp_q.pop_front());
         end
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.a_in, bus.b_in, bus.sub_in));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a pair and hold it until accepted (bounded)
   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      logic acc;
      int   n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.a_in     = a;
      bus.b_in     = b;
      bus.sub_in   = sub;
      do begin
         @(negedge clk);
         acc = bus.in_ready;
         tick();
         n++;
      end while (!acc && n < BOUND);
      if (!acc) begin
         n_checks++;
         n_errors++;
         $display("FAIL drive_timeout: pair a=0x%08h not accepted in %0d cycles", a, BOUND);
      end
   endtask

   // Present a pair for one cycle only; report whether it was taken
   task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output logic acc);
      bus.in_valid = 1'b1;
      bus.a_in     = a;
      bus.b_in     = b;
      bus.sub_in   = sub;
      @(negedge clk);
      acc = bus.in_ready;
      tick();
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      while (exp_q.size() != 0 && n < BOUND) begin
         tick();
         n++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic         acc1, acc2, acc3;
      logic         exp2;
      int           c0;
      logic [W-1:0] xa [3];
      logic [W-1:0] xb [3];
      logic         xs [3];
      bit           stim_done;

      n_checks = 0;
      n_errors = 0;
      cyc      = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a_in      = '0;
      bus.b_in      = '0;
      bus.sub_in    = 1'b0;
      bus.out_ready = 1'b1;

      // model pins (hand-computed)
      pin("pin_add",  32'h5,        32'h3, 1'b0, 32'h00000001, 32'h00000006, 1'b0, 32'h00000008);
      pin("pin_sub",  32'h5,        32'h3, 1'b1, 32'h00000005, 32'hFFFFFFF9, 1'b1, 32'h00000002);
      pin("pin_ovf",  32'hFFFFFFFF, 32'h1, 1'b0, 32'h00000001, 32'hFFFFFFFE, 1'b0, 32'h00000000);
      pin("pin_zsub", 32'h0,        32'h0, 1'b1, 32'h00000001, 32'hFFFFFFFF, 1'b1, 32'h00000000);

      // reset state while rst_n is low
      #3;
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_g",         bus.g_out, 32'd0);
      check("rst_p",         bus.p_out, 32'd0);
      check("rst_cin",       {31'd0, bus.cin_out}, 32'd0);
      check("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // directed vectors through the DUT
      drive(32'h5,        32'h3, 1'b0);
      drive(32'h5,        32'h3, 1'b1);
      drive(32'hFFFFFFFF, 32'h1, 1'b0);
      drive(32'h0,        32'h0, 1'b1);
      drive(32'h80000000, 32'h80000000, 1'b0);
      drive(32'h0,        32'h1, 1'b1);
      drain();

      // backpressure: X1, X2, X3 on consecutive cycles with out_ready low
      xa[0] = 32'h11111111; xb[0] = 32'h01010101; xs[0] = 1'b0;
      xa[1] = 32'h22222222; xb[1] = 32'h33333333; xs[1] = 1'b1;
      xa[2] = 32'hDEADBEEF; xb[2] = 32'h12345678; xs[2] = 1'b0;
      bus.out_ready = 1'b0;
      offer(xa[0], xb[0], xs[0], acc1);
      offer(xa[1], xb[1], xs[1], acc2);
      offer(xa[2], xb[2], xs[2], acc3);
      bus.in_valid = 1'b0;
`ifdef KSA_STAGE1_SKID_EN
      exp2 = 1'b1;
`else
      exp2 = 1'b0;
`endif
      check("bp_acc_x1", {31'd0, acc1}, 32'd1);
      check("bp_acc_x2", {31'd0, acc2}, {31'd0, exp2});
      check("bp_acc_x3", {31'd0, acc3}, 32'd0);
      repeat (3) tick();
      bus.out_ready = 1'b1;
      if (!acc2) drive(xa[1], xb[1], xs[1]);
      drive(xa[2], xb[2], xs[2]);
      drain();

      // streaming: one result per cycle
      c0 = cyc;
      for (int i = 0; i < 100; i++)
         drive(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      check("stream_cycles", cyc - c0, 32'd100);
      drain();

      // random backpressure with gaps
      stim_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               drive(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
               if ($urandom_range(0, 2) == 0) begin
                  bus.in_valid = 1'b0;
                  tick();
               end
            end
            bus.in_valid = 1'b0;
            stim_done    = 1'b1;
         end
         begin
            while (!stim_done) begin
               bus.out_ready = 1'($urandom_range(0, 1));
               tick();
            end
            bus.out_ready = 1'b1;
         end
      join
      drain();

      // reset while a result is held
      bus.out_ready = 1'b0;
      drive(32'hCAFEF00D, 32'h0BADBEEF, 1'b1);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("mid_rst_g",         bus.g_out, 32'd0);
      check("mid_rst_p",         bus.p_out, 32'd0);
      check("mid_rst_cin",       {31'd0, bus.cin_out}, 32'd0);
      check("mid_rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      tick();
      bus.out_ready = 1'b1;
      drive(32'h00000007, 32'h00000009, 1'b1);
      drain();

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
